// File: rtl/distance_bcd_display_pkg.sv
// Shared types and constants for the distance BCD display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package distance_bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int SHIFT_CYCLES   = 16;
  localparam int BCD_DIGITS     = 5;
  localparam int OVERFLOW_LIMIT = 9999;
  localparam int DIST_W         = 16;
  localparam int BCD_W          = 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(
    input logic [BCD_W-1:0] s
  );
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/distance_bcd_display_if.sv
// Distance input and display-side outputs of the BCD display block.
// The master drives Distance; the slave produces everything else.
interface distance_bcd_display_if;
  import distance_bcd_display_pkg::*;

  logic [DIST_W-1:0] Distance;
  logic [BCD_W-1:0]  Bcd;
  logic [6:0]        Hex0;
  logic [6:0]        Hex1;
  logic [6:0]        Hex2;
  logic [6:0]        Hex3;
  logic              Overflow;
  logic              Update;
  logic              Busy;

  modport master (
    output Distance,
    input  Bcd,
    input  Hex0,
    input  Hex1,
    input  Hex2,
    input  Hex3,
    input  Overflow,
    input  Update,
    input  Busy
  );

  modport slave (
    input  Distance,
    output Bcd,
    output Hex0,
    output Hex1,
    output Hex2,
    output Hex3,
    output Overflow,
    output Update,
    output Busy
  );

endinterface

// File: rtl/distance_bcd_display_bcd_to_seven_seg.sv
// One BCD digit to an active-low 7-segment pattern, with blanking.
// Codes above 9 never occur in practice and show a dash.
module bcd_to_seven_seg
  import distance_bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/distance_bcd_display.sv
// Iterative double-dabble of Distance into 5 BCD digits, driving
// four 7-segment displays; reconverts only when Distance changes.
module distance_bcd_display
  import distance_bcd_display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  distance_bcd_display_if.slave  bus
);

  state_e state_q, state_d;

  logic [DIST_W-1:0] bin_q, bin_d;
  logic [DIST_W-1:0] lat_q, lat_d;
  logic [DIST_W-1:0] last_q, last_d;
  logic [BCD_W-1:0]  scr_q, scr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;

  logic [BCD_W-1:0]  bcd_q;
  logic              ovf_q;
  logic              upd_q;
  logic [3:0][6:0]   hex_q;

  logic              busy;
  logic              done;
  logic              capture;
  logic              ovf_d;
  logic [3:0]        blank;
  logic [3:0][6:0]   seg_raw;
  logic [3:0][6:0]   hex_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || (bus.Distance != last_q)) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 4'(SHIFT_CYCLES - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    capture = (state_q == ST_IDLE) && (state_d == ST_SHIFT);
  end

  always_comb begin
    bin_d  = bin_q;
    lat_d  = lat_q;
    last_d = last_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (capture) begin
      bin_d  = bus.Distance;
      lat_d  = bus.Distance;
      scr_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end
    if (state_q == ST_SHIFT) begin
      {scr_d, bin_d} = {add3(scr_q), bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
    end
    if (done) begin
      last_d = lat_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bin_q  <= '0;
      lat_q  <= '0;
      last_q <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b1;
    end else begin
      bin_q  <= bin_d;
      lat_q  <= lat_d;
      last_q <= last_d;
      scr_q  <= scr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  // Leading-zero blanking: digit N dark when it and all above are 0.
  always_comb begin
    ovf_d    = (scr_q[19:16] != 4'd0);
    blank    = '0;
    blank[3] = BLANK_LEADING && (scr_q[15:12] == 4'd0);
    blank[2] = blank[3] && (scr_q[11:8] == 4'd0);
    blank[1] = blank[2] && (scr_q[7:4] == 4'd0);
  end

  for (genvar n = 0; n < 4; n++) begin : g_seg
    bcd_to_seven_seg u_seg (
      .bcd_i   (scr_q[4*n +: 4]),
      .blank_i (blank[n]),
      .seg_o   (seg_raw[n])
    );
    assign hex_d[n] = ovf_d ? SEG_DASH : seg_raw[n];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
      upd_q <= 1'b0;
      hex_q <= {4{SEG_BLANK}};
    end else begin
      upd_q <= done;
      if (done) begin
        bcd_q <= scr_q;
        ovf_q <= ovf_d;
        hex_q <= hex_d;
      end
    end
  end

  assign bus.Bcd      = bcd_q;
  assign bus.Overflow = ovf_q;
  assign bus.Update   = upd_q;
  assign bus.Busy     = busy;
  assign bus.Hex0     = hex_q[0];
  assign bus.Hex1     = hex_q[1];
  assign bus.Hex2     = hex_q[2];
  assign bus.Hex3     = hex_q[3];

endmodule
